operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 43 ++++
 rtl/operand_fetch.sv | 180 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_if
//
// Bundles the two handshake channels of operand_fetch:
//   in_*  : instruction handshake from fetch (valid/ready, instr, pc)
//   out_* : resolved-operand handshake to execute (valid/ready, pc, instr,
//           rs1/rs2 values, rd index, rd write enable)
//
// Modports:
//   slave  : the operand_fetch side (consumes in_*, produces out_*)
//   master : the surrounding pipeline / testbench side
// ---------------------------------------------------------------------------
interface operand_fetch_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_rs1_val;
   logic [31:0] out_rs2_val;
   logic [4:0]  out_rd_idx;
   logic        out_rd_we;

   modport slave (
      input  in_valid, in_instr, in_pc,
      output in_ready,
      output out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val,
             out_rd_idx, out_rd_we,
      input  out_ready
   );

   modport master (
      output in_valid, in_instr, in_pc,
      input  in_ready,
      input  out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val,
             out_rd_idx, out_rd_we,
      output out_ready
   );
endinterface

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Two-stage operand fetch for an RV32 pipeline. S1 captures an instruction
// from fetch and presents its source indices to a combinational register
// file; OUT holds the instruction with its resolved operand values until
// execute accepts it. A 32-bit busy scoreboard tracks registers that have an
// issued-but-not-written-back producer and stalls S1 on read-after-write.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   bus (slave)            in_* handshake from fetch, out_* handshake to execute
//   rs1_idx, rs2_idx       register-file read indices (from the S1 instruction)
//   rs1_data, rs2_data     combinational register-file read data
//   wb_we/wb_rd_idx/_data  write-back port (also drives the register file)
//   flush                  drop both stages; scoreboard is left alone
//
// Configuration:
//   OPFETCH_BYPASS_EN      when defined, a source matching the write-back in
//                          the same cycle takes wb_rd_data and does not stall.
//                          When undefined, the stage waits for the busy bit to
//                          clear and reads the register file a cycle later.
// ---------------------------------------------------------------------------
module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   operand_fetch_if.slave bus,
   output logic [4:0]  rs1_idx,
   output logic [4:0]  rs2_idx,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd_idx,
   input  logic [31:0] wb_rd_data,
   input  logic        flush
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // S1 stage
   logic        s1_valid_reg;
   logic [31:0] s1_pc_reg;
   logic [31:0] s1_instr_reg;

   // OUT stage
   logic        out_valid_reg;
   logic [31:0] out_pc_reg;
   logic [31:0] out_instr_reg;
   logic [31:0] out_rs1_reg;
   logic [31:0] out_rs2_reg;
   logic [4:0]  out_rd_idx_reg;
   logic        out_rd_we_reg;

   // Scoreboard
   logic [31:0] busy_reg;
   logic [31:0] busy_next;

   // Decode of the S1 instruction
   logic [6:0]       opcode;
   logic [4:0]       rd_idx;
   logic             rd_we;
   logic [1:0]       src_used;
   logic [1:0][4:0]  src_idx;
   logic [1:0][31:0] src_data;
   logic [1:0]       src_fwd;
   logic [1:0]       src_hazard;
   logic [1:0][31:0] src_val;

   logic hazard;
   logic s1_advance;
   logic in_ready;
   logic in_fire;

   assign opcode     = s1_instr_reg[6:0];
   assign rd_idx     = s1_instr_reg[11:7];
   assign src_idx[0] = s1_instr_reg[19:15];
   assign src_idx[1] = s1_instr_reg[24:20];
   assign src_data   = {rs2_data, rs1_data};

   assign src_used[0] = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign src_used[1] = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
   assign rd_we       = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd_idx != 5'd0);

   assign rs1_idx = src_idx[0];
   assign rs2_idx = src_idx[1];

   // Per-source resolution: unused sources and x0 contribute 0 and never stall.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic live;
         assign live = src_used[gi] && (src_idx[gi] != 5'd0);
`ifdef OPFETCH_BYPASS_EN
         // The register file is written at the same edge this operand would
         // be captured, so take the write-back value directly.
         assign src_fwd[gi] = live && wb_we && (wb_rd_idx == src_idx[gi]);
`else
         assign src_fwd[gi] = 1'b0;
`endif
         assign src_hazard[gi] = live && busy_reg[src_idx[gi]] && !src_fwd[gi];
         assign src_val[gi]    = !live      ? 32'd0 :
                                 src_fwd[gi] ? wb_rd_data : src_data[gi];
      end
   endgenerate

   assign hazard     = |src_hazard;
   assign s1_advance = s1_valid_reg && !hazard && (!out_valid_reg || bus.out_ready);
   assign in_ready   = !s1_valid_reg || s1_advance;
   assign in_fire    = bus.in_valid && in_ready;

   // Busy update: set on issue beats clear on write-back for the same index.
   // Flush does not touch this path, so an issue in a flush cycle still marks
   // its destination busy.
   generate
      for (gi = 0; gi < 32; gi++) begin : g_busy
         if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
         end else begin : g_bit
            assign busy_next[gi] =
               (s1_advance && rd_we && (rd_idx == 5'(gi))) ? 1'b1 :
               (wb_we && (wb_rd_idx == 5'(gi)))            ? 1'b0 :
                                                             busy_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg   <= 1'b0;
         s1_pc_reg      <= 32'd0;
         s1_instr_reg   <= 32'd0;
         out_valid_reg  <= 1'b0;
         out_pc_reg     <= 32'd0;
         out_instr_reg  <= 32'd0;
         out_rs1_reg    <= 32'd0;
         out_rs2_reg    <= 32'd0;
         out_rd_idx_reg <= 5'd0;
         out_rd_we_reg  <= 1'b0;
         busy_reg       <= 32'd0;
      end else begin
         busy_reg <= busy_next;
         if (flush) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
         end else begin
            s1_valid_reg  <= in_fire || (s1_valid_reg && !s1_advance);
            out_valid_reg <= s1_advance || (out_valid_reg && !bus.out_ready);
            if (in_fire) begin
               s1_pc_reg    <= bus.in_pc;
               s1_instr_reg <= bus.in_instr;
            end
            // OUT only reloads when empty or being consumed, which keeps it
            // stable while execute back-pressures.
            if (s1_advance) begin
               out_pc_reg     <= s1_pc_reg;
               out_instr_reg  <= s1_instr_reg;
               out_rs1_reg    <= src_val[0];
               out_rs2_reg    <= src_val[1];
               out_rd_idx_reg <= rd_idx;
               out_rd_we_reg  <= rd_we;
            end
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_pc      = out_pc_reg;
   assign bus.out_instr   = out_instr_reg;
   assign bus.out_rs1_val = out_rs1_reg;
   assign bus.out_rs2_val = out_rs2_reg;
   assign bus.out_rd_idx  = out_rd_idx_reg;
   assign bus.out_rd_we   = out_rd_we_reg;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
   localparam logic [31:0] ADD_X3      = 32'h0020_81B3;
   localparam logic [31:0] ADDI_X4     = 32'h0010_0213;
   localparam logic [31:0] ADDI_X5     = 32'h0020_0293;
   localparam logic [31:0] ADDI_X6     = 32'h0030_0313;
   localparam logic [31:0] SW_X2_X1    = 32'h0020_A023;
   localparam logic [31:0] LUI_X5      = 32'h1234_52B7;
   localparam logic [31:0] ADDI_X1_7   = 32'h0070_0093;
   localparam logic [31:0] ADD_X1_X1X2 = 32'h0020_80B3;
   localparam logic [31:0] ADD_X7_X1   = 32'h0000_83B3;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_idx, rs2_idx;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd_idx;
   logic [31:0] wb_rd_data;
   logic        flush;

   always #5 clk = ~clk;

   operand_fetch_if bus();

   operand_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .rs1_idx    (rs1_idx),
      .rs2_idx    (rs2_idx),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .wb_we      (wb_we),
      .wb_rd_idx  (wb_rd_idx),
      .wb_rd_data (wb_rd_data),
      .flush      (flush)
   );

   // Register file owned by the bench (x0 stays 0).
   logic [31:0] rf [32];
   assign rs1_data = rf[rs1_idx];
   assign rs2_data = rf[rs2_idx];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
   } s1_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
   } out_t;

   s1_t         m_s1;
   out_t        m_out;
   logic [31:0] m_busy;
   int          retire_q[$];
   bit          last_fire;
   logic        pend_we;
   logic [4:0]  pend_idx;
   logic [31:0] pend_dat;

   function automatic bit uses_rs1(input logic [31:0] i);
      return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
   endfunction

   function automatic bit uses_rs2(input logic [31:0] i);
      return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit writes_rd(input logic [31:0] i);
      return !(i[6:0] inside {7'b0100011, 7'b1100011}) && (i[11:7] != 5'd0);
   endfunction

   function automatic bit blocked(input logic [4:0] idx, input bit used,
                                  input logic we, input logic [4:0] widx);
      if (!used || idx == 5'd0 || !m_busy[idx]) return 1'b0;
      return !(BYP && we && widx == idx);
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] idx, input bit used,
                                           input logic we, input logic [4:0] widx,
                                           input logic [31:0] wdat);
      if (!used || idx == 5'd0) return 32'd0;
      if (BYP && we && widx == idx) return wdat;
      return rf[idx];
   endfunction

   // One clock cycle: drive, compare against the model, advance both.
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic we, input logic [4:0] widx,
                        input logic [31:0] wdat, input logic fl, input logic rst);
      s1_t  n_s1;
      out_t n_out;
      bit   adv, rdy;
      logic [4:0] a, b;
      if (pend_we && pend_idx != 5'd0) rf[pend_idx] = pend_dat;
      pend_we       = 1'b0;
      reset         = rst;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      wb_we         = we;
      wb_rd_idx     = widx;
      wb_rd_data    = wdat;
      #1;
      a   = m_s1.instr[19:15];
      b   = m_s1.instr[24:20];
      adv = m_s1.v && !blocked(a, uses_rs1(m_s1.instr), we, widx)
                   && !blocked(b, uses_rs2(m_s1.instr), we, widx)
                   && (!m_out.v || ordy);
      rdy = !m_s1.v || adv;
      if (!rst) begin
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
         check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_out.v});
         if (m_s1.v) begin
            check("rs1_idx", {27'd0, rs1_idx}, {27'd0, a});
            check("rs2_idx", {27'd0, rs2_idx}, {27'd0, b});
         end
         if (m_out.v) begin
            check("out_pc", bus.out_pc, m_out.pc);
            check("out_instr", bus.out_instr, m_out.instr);
            check("out_rs1_val", bus.out_rs1_val, m_out.a);
            check("out_rs2_val", bus.out_rs2_val, m_out.b);
            check("out_rd_idx", {27'd0, bus.out_rd_idx}, {27'd0, m_out.rd});
            check("out_rd_we", {31'd0, bus.out_rd_we}, {31'd0, m_out.we});
         end
      end
      n_s1  = m_s1;
      n_out = m_out;
      last_fire = 1'b0;
      if (rst) begin
         n_s1   = '0;
         n_out  = '0;
         m_busy = '0;
         retire_q.delete();
      end else begin
         if (m_out.v && ordy) begin
            if (!fl && m_out.we) retire_q.push_back(int'(m_out.rd));
            n_out.v = 1'b0;
         end
         if (adv) begin
            n_out.v     = 1'b1;
            n_out.pc    = m_s1.pc;
            n_out.instr = m_s1.instr;
            n_out.a     = operand(a, uses_rs1(m_s1.instr), we, widx, wdat);
            n_out.b     = operand(b, uses_rs2(m_s1.instr), we, widx, wdat);
            n_out.rd    = m_s1.instr[11:7];
            n_out.we    = writes_rd(m_s1.instr);
            n_s1.v      = 1'b0;
         end
         if (iv && rdy) begin
            n_s1.v     = 1'b1;
            n_s1.pc    = pc;
            n_s1.instr = ins;
            last_fire  = !fl;
         end
         if (fl) begin
            n_s1.v  = 1'b0;
            n_out.v = 1'b0;
         end
         // write-back clears first, a same-cycle issue to that register re-sets it
         if (we && widx != 5'd0) m_busy[widx] = 1'b0;
         if (adv && writes_rd(m_s1.instr)) m_busy[m_s1.instr[11:7]] = 1'b1;
      end
      pend_we  = we;
      pend_idx = widx;
      pend_dat = wdat;
      @(posedge clk);
      m_s1  = n_s1;
      m_out = n_out;
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
      cycle(1'b1, ins, pc, ordy, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'd0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 7))
         0: w[6:0] = 7'b0110011;
         1: w[6:0] = 7'b0010011;
         2: w[6:0] = 7'b0100011;
         3: w[6:0] = 7'b1100011;
         4: w[6:0] = 7'b0110111;
         5: w[6:0] = 7'b0010111;
         6: w[6:0] = 7'b1101111;
         default: w[6:0] = 7'b0000011;
      endcase
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   initial begin
      logic [31:0] cur_instr, cur_pc;
      bit          have;
      logic        iv, ordy, we;
      logic [4:0]  widx;
      logic [31:0] wdat;

      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i) * 32'h111;
      m_s1 = '0; m_out = '0; m_busy = '0; pend_we = 1'b0;
      reset = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd_idx = 5'd0; wb_rd_data = 32'd0;
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b0;
      @(negedge clk);

      // reset state and first instruction latency
      do_reset();
      do_reset();
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_rd_we", {31'd0, bus.out_rd_we}, 32'd0);
      check("rst_out_rd_idx", {27'd0, bus.out_rd_idx}, 32'd0);
      check("rst_out_pc", bus.out_pc, 32'd0);
      send(ADDI_X1_5, 32'h100, 1'b1);
      check("lat_edge_k", {31'd0, bus.out_valid}, 32'd0);
      send(ADD_X3, 32'h104, 1'b1);
      check("addi_valid", {31'd0, bus.out_valid}, 32'd1);
      check("addi_rd_idx", {27'd0, bus.out_rd_idx}, 32'd1);
      check("addi_rd_we", {31'd0, bus.out_rd_we}, 32'd1);
      idle(1'b1);
      check("add_stalled", {31'd0, bus.out_valid}, 32'd0);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0);
      if (!BYP) begin
         check("nobyp_still_stalled", {31'd0, bus.out_valid}, 32'd0);
         idle(1'b1);
      end
      check("add_issue", {31'd0, bus.out_valid}, 32'd1);
      check("add_rs1_val", bus.out_rs1_val, 32'd5);
      check("add_rd_idx", {27'd0, bus.out_rd_idx}, 32'd3);
      idle(1'b1);

      // back-pressure with both stages full
      do_reset();
      send(ADDI_X4, 32'h200, 1'b0);
      send(ADDI_X5, 32'h204, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send(ADDI_X6, 32'h208, 1'b0);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_out_pc", bus.out_pc, 32'h200);
         check("bp_out_rd_idx", {27'd0, bus.out_rd_idx}, 32'd4);
      end
      send(ADDI_X6, 32'h208, 1'b1);
      check("rel1_valid", {31'd0, bus.out_valid}, 32'd1);
      check("rel1_rd_idx", {27'd0, bus.out_rd_idx}, 32'd5);
      idle(1'b1);
      check("rel2_valid", {31'd0, bus.out_valid}, 32'd1);
      check("rel2_rd_idx", {27'd0, bus.out_rd_idx}, 32'd6);
      idle(1'b1);

      // store and lui decode
      do_reset();
      send(SW_X2_X1, 32'h300, 1'b1);
      send(LUI_X5, 32'h304, 1'b1);
      check("sw_rd_we", {31'd0, bus.out_rd_we}, 32'd0);
      check("sw_rs1_val", bus.out_rs1_val, 32'd5);
      check("sw_rs2_val", bus.out_rs2_val, 32'h1000_0222);
      idle(1'b1);
      check("lui_rd_idx", {27'd0, bus.out_rd_idx}, 32'd5);
      check("lui_rs1_val", bus.out_rs1_val, 32'd0);
      check("lui_rs2_val", bus.out_rs2_val, 32'd0);
      idle(1'b1);

      // flush while stalled, with write-back and same-rd issue in that cycle
      do_reset();
      send(ADDI_X1_7, 32'h400, 1'b1);
      send(ADD_X1_X1X2, 32'h404, 1'b1);
      idle(1'b1);
      check("fl_stalled", {31'd0, bus.out_valid}, 32'd0);
      cycle(1'b1, LUI_X5, 32'h408, 1'b1, 1'b1, 5'd1, 32'h99, 1'b1, 1'b0);
      check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("fl_s1_empty", {31'd0, bus.in_ready}, 32'd1);
      send(ADD_X7_X1, 32'h40C, 1'b1);
      idle(1'b1);
      check("fl_busy_x1", {31'd0, bus.out_valid}, BYP ? 32'd0 : 32'd1);

      // reset in the middle of a stall
      do_reset();
      send(ADDI_X1_5, 32'h500, 1'b1);
      send(ADD_X3, 32'h504, 1'b1);
      idle(1'b1);
      cycle(1'b1, ADDI_X4, 32'h508, 1'b1, 1'b1, 5'd1, 32'd7, 1'b0, 1'b1);
      check("rs_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rs_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rs_out_rd_we", {31'd0, bus.out_rd_we}, 32'd0);
      send(ADD_X3, 32'h50C, 1'b1);
      idle(1'b1);
      check("rs_busy_clear", {31'd0, bus.out_valid}, 32'd1);
      check("rs_issue_pc", bus.out_pc, 32'h50C);

      // randomized traffic against the model
      do_reset();
      have   = 1'b0;
      cur_pc = 32'h1000;
      for (int n = 0; n < 3000; n++) begin
         if (!have) begin
            cur_instr = rand_instr();
            have      = 1'b1;
         end
         iv   = ($urandom_range(0, 9) < 8);
         ordy = ($urandom_range(0, 3) != 0);
         we   = 1'b0;
         widx = 5'd0;
         wdat = 32'd0;
         if (retire_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            we   = 1'b1;
            widx = 5'(retire_q.pop_front());
            wdat = $urandom;
         end
         cycle(iv, cur_instr, cur_pc, ordy, we, widx, wdat, 1'b0, 1'b0);
         if (last_fire) begin
            have   = 1'b0;
            cur_pc = cur_pc + 32'd4;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
